// File: rtl/matmul_seq_ctrl_if.sv
// Handshake, operand-read, MAC-strobe and result-write bundle of the matmul sequencer.
// The slave side is the controller; the master side is the surrounding engine.
interface matmul_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic              abort;
  logic              a_loaded;
  logic              b_loaded;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              mac_clr;
  logic              mac_en;
  logic              mac_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       cycle_count;
  logic [31:0]       stall_count;

  modport master (
    output start, abort, a_loaded, b_loaded, wr_ready,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, mac_clr, mac_en, mac_last,
    input  wr_en, wr_addr_r, cycle_count, stall_count
  );

  modport slave (
    input  start, abort, a_loaded, b_loaded, wr_ready,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, mac_clr, mac_en, mac_last,
    output wr_en, wr_addr_r, cycle_count, stall_count
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer walking R = A x B element by element over a shared MAC datapath.
// Define MATMUL_SEQ_PERF_EN to build the saturating busy-cycle and write-stall counters.
module matmul_seq_ctrl #(
  parameter int unsigned M_ROWS  = 10,
  parameter int unsigned K_DEPTH = 10,
  parameter int unsigned N_COLS  = 10,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input logic              clk,
  input logic              rst_n,
  matmul_seq_ctrl_if.slave bus
);

  localparam int unsigned I_W = (M_ROWS  > 1) ? $clog2(M_ROWS)  : 1;
  localparam int unsigned J_W = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;
  localparam int unsigned K_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int unsigned D_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state;
  logic [I_W-1:0]    i;
  logic [J_W-1:0]    j;
  logic [K_W-1:0]    k;
  logic [D_W-1:0]    drain_cnt;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_r;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic              rd_last;
  logic              mac_clr;

  logic accept;
  logic abort_hit;
  logic last_elem;

  assign accept    = (state == S_IDLE) && bus.start && bus.a_loaded && bus.b_loaded;
  assign abort_hit = (state != S_IDLE) && bus.abort;
  assign last_elem = (i == I_W'(M_ROWS - 1)) && (j == J_W'(N_COLS - 1));

  // The write must be granted in the same cycle wr_ready is seen, so the strobe is
  // decoded from the state register; a simultaneous abort suppresses it.
  assign bus.wr_en = (state == S_STORE) && bus.wr_ready && !bus.abort;

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = addr_a;
  assign bus.rd_addr_b = addr_b;
  assign bus.mac_clr   = mac_clr;
  assign bus.wr_addr_r = addr_r;

  // Sequencer: addresses advance by running offsets, never by multiplication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      drain_cnt <= '0;
      a_base    <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_r    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_last   <= 1'b0;
      mac_clr   <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_last <= 1'b0;
      mac_clr <= 1'b0;
      if (abort_hit) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        k         <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state   <= S_CLEAR;
              busy    <= 1'b1;
              mac_clr <= 1'b1;
              i       <= '0;
              j       <= '0;
              k       <= '0;
              a_base  <= '0;
              addr_r  <= '0;
            end
          end
          S_CLEAR: begin
            state   <= S_ISSUE;
            rd_en   <= 1'b1;
            rd_last <= (K_DEPTH == 32'd1);
            k       <= '0;
            addr_a  <= a_base;
            addr_b  <= ADDR_W'(j);
          end
          S_ISSUE: begin
            if (k == K_W'(K_DEPTH - 1)) begin
              k         <= '0;
              drain_cnt <= '0;
              state     <= (RD_LAT > 0) ? S_DRAIN : S_STORE;
            end else begin
              k       <= K_W'(k + 1'b1);
              rd_en   <= 1'b1;
              rd_last <= (K_W'(k + 1'b1) == K_W'(K_DEPTH - 1));
              addr_a  <= addr_a + ADDR_W'(1);
              addr_b  <= addr_b + ADDR_W'(N_COLS);
            end
          end
          S_DRAIN: begin
            if (drain_cnt == D_W'(RD_LAT - 1)) begin
              state <= S_STORE;
            end else begin
              drain_cnt <= D_W'(drain_cnt + 1'b1);
            end
          end
          S_STORE: begin
            if (bus.wr_ready) begin
              addr_r <= addr_r + ADDR_W'(1);
              if (j == J_W'(N_COLS - 1)) begin
                j      <= '0;
                i      <= I_W'(i + 1'b1);
                a_base <= a_base + ADDR_W'(K_DEPTH);
              end else begin
                j <= J_W'(j + 1'b1);
              end
              if (last_elem) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state   <= S_CLEAR;
                mac_clr <= 1'b1;
                k       <= '0;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-valid delay line aligning mac_en/mac_last with operand data.
  if (RD_LAT == 0) begin : g_pipe_bypass
    assign bus.mac_en   = rd_en;
    assign bus.mac_last = rd_last;
  end else begin : g_pipe
    logic [RD_LAT-1:0] en_pipe;
    logic [RD_LAT-1:0] last_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_pipe   <= '0;
        last_pipe <= '0;
      end else if (abort_hit) begin
        en_pipe   <= '0;
        last_pipe <= '0;
      end else begin
        en_pipe   <= RD_LAT'({en_pipe, rd_en});
        last_pipe <= RD_LAT'({last_pipe, rd_last});
      end
    end

    assign bus.mac_en   = en_pipe[RD_LAT-1];
    assign bus.mac_last = last_pipe[RD_LAT-1];
  end

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] stall_count;

  // Both counters restart with each accepted job and saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (accept) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (busy && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if ((state == S_STORE) && !bus.wr_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  assign bus.cycle_count = cycle_count;
  assign bus.stall_count = stall_count;
`else
  assign bus.cycle_count = '0;
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl on a 2x2x2 problem, RD_LAT=1 (main) and RD_LAT=0.
module tb_matmul_seq_ctrl;

  localparam int unsigned M  = 2;
  localparam int unsigned K  = 2;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.ADDR_W(AW)) bus1 ();
  matmul_seq_ctrl_if #(.ADDR_W(AW)) bus0 ();

  matmul_seq_ctrl #(.M_ROWS(M), .K_DEPTH(K), .N_COLS(N), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  matmul_seq_ctrl #(.M_ROWS(M), .K_DEPTH(K), .N_COLS(N), .ADDR_W(AW), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] rd_q[$];
  int          wr_q[$];
  int          lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected read pairs, write addresses and busy-cycle latency of one whole job.
  task automatic push_job(input int lat);
    for (int ii = 0; ii < int'(M); ii++) begin
      for (int jj = 0; jj < int'(N); jj++) begin
        for (int kk = 0; kk < int'(K); kk++) begin
          rd_q.push_back({16'(ii * int'(K) + kk), 16'(kk * int'(N) + jj)});
        end
        wr_q.push_back(ii * int'(N) + jj);
      end
    end
    lat_q.push_back(lat);
  endtask

  task automatic clear_sb();
    rd_q.delete();
    wr_q.delete();
    lat_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk) #1 bus1.start = 1'b1;
    @(posedge clk) #1 bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus1.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    chk({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(lat_q.size()), 32'd0);
  endtask

  task automatic chk_perf(input string tag, input int cyc_exp, input int stall_exp);
`ifdef MATMUL_SEQ_PERF_EN
    chk({tag, "_cycle_count"}, bus1.cycle_count, 32'(cyc_exp));
    chk({tag, "_stall_count"}, bus1.stall_count, 32'(stall_exp));
`else
    chk({tag, "_cycle_count"}, bus1.cycle_count, 32'd0 & 32'(cyc_exp));
    chk({tag, "_stall_count"}, bus1.stall_count, 32'd0 & 32'(stall_exp));
`endif
  endtask

  // Monitor for the RD_LAT=1 instance: pops expectations as the DUT produces them.
  logic        busy1_q = 1'b0;
  int          acc1 = 0;
  int          mac_cnt = 0;
  int          last_cnt = 0;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy1_q  = 1'b0;
      mac_cnt  = 0;
      last_cnt = 0;
    end else begin
      if (bus1.busy && !busy1_q) acc1 = cyc;
      busy1_q = bus1.busy;
      if (bus1.mac_clr) begin
        mac_cnt  = 0;
        last_cnt = 0;
      end
      if (bus1.mac_en) mac_cnt++;
      if (bus1.mac_last) begin
        last_cnt++;
        chk("mac_last_pos", 32'(mac_cnt), 32'(K));
      end
      if (bus1.rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(bus1.rd_en), 32'd0);
        else begin
          e_rd = rd_q.pop_front();
          chk("rd_addr_a", 32'(bus1.rd_addr_a), 32'(e_rd[31:16]));
          chk("rd_addr_b", 32'(bus1.rd_addr_b), 32'(e_rd[15:0]));
        end
      end
      if (bus1.wr_en) begin
        chk("mac_en_per_elem", 32'(mac_cnt), 32'(K));
        chk("mac_last_per_elem", 32'(last_cnt), 32'd1);
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(bus1.wr_en), 32'd0);
        else chk("wr_addr_r", 32'(bus1.wr_addr_r), 32'(wr_q.pop_front()));
      end
      if (bus1.done) begin
        chk("done_busy", 32'(bus1.busy), 32'd1);
        if (lat_q.size() == 0) chk("done_unexpected", 32'(bus1.done), 32'd0);
        else chk("done_latency", 32'(cyc - acc1 + 1), 32'(lat_q.pop_front()));
      end
    end
  end

  // Monitor for the RD_LAT=0 instance.
  logic busy0_q = 1'b0;
  int   acc0 = 0;
  int   coinc0 = 0;
  int   mac0 = 0;
  int   wr0 = 0;
  int   done0 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.busy && !busy0_q) acc0 = cyc;
      busy0_q = bus0.busy;
      if (bus0.mac_en && bus0.rd_en) coinc0++;
      if (bus0.mac_en) mac0++;
      if (bus0.wr_en) wr0++;
      if (bus0.done) begin
        done0++;
        chk("lat0_done_latency", 32'(cyc - acc0 + 1), 32'd17);
      end
    end
  end

  initial begin
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.a_loaded = 1'b1; bus1.b_loaded = 1'b1;
    bus1.wr_ready = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.a_loaded = 1'b1; bus0.b_loaded = 1'b1;
    bus0.wr_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_strobes", 32'({bus1.done, bus1.rd_en, bus1.mac_clr, bus1.mac_en,
                            bus1.mac_last, bus1.wr_en}), 32'd0);
    chk("rst_addrs", 32'({bus1.rd_addr_a, bus1.wr_addr_r}), 32'd0);
    chk("rst_busy0", 32'(bus0.busy), 32'd0);
    rst_n = 1'b1;

    // Plain full job.
    push_job(21);
    pulse_start();
    wait_idle("t1");
    chk_perf("t1", 21, 0);

    // Zero read latency instance.
    @(posedge clk) #1 bus0.start = 1'b1;
    @(posedge clk) #1 bus0.start = 1'b0;
    for (int n = 0; n < 200 && bus0.busy; n++) @(negedge clk);
    chk("lat0_idle", 32'(bus0.busy), 32'd0);
    chk("lat0_mac_coincident", 32'(coinc0), 32'(M * N * K));
    chk("lat0_mac_total", 32'(mac0), 32'(M * N * K));
    chk("lat0_writes", 32'(wr0), 32'(M * N));
    chk("lat0_dones", 32'(done0), 32'd1);

    // Three stalled cycles on element (0,1).
    push_job(24);
    pulse_start();
    repeat (9) @(posedge clk);
    #1 bus1.wr_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_wr_en", 32'(bus1.wr_en), 32'd0);
      chk("stall_wr_addr", 32'(bus1.wr_addr_r), 32'd1);
      @(posedge clk);
    end
    #1 bus1.wr_ready = 1'b1;
    wait_idle("t3");
    chk_perf("t3", 24, 3);

    // Start without B loaded is dropped, then a normal run with a stray start mid-job.
    bus1.b_loaded = 1'b0;
    pulse_start();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("noload_busy", 32'(bus1.busy), 32'd0);
      chk("noload_strobes", 32'({bus1.rd_en, bus1.mac_clr, bus1.wr_en}), 32'd0);
    end
    bus1.b_loaded = 1'b1;
    push_job(21);
    pulse_start();
    repeat (6) @(posedge clk);
    #1 bus1.start = 1'b1;
    @(posedge clk) #1 bus1.start = 1'b0;
    wait_idle("t4");

    // Abort during the first issue cycle of element (1,0).
    push_job(21);
    pulse_start();
    repeat (11) @(posedge clk);
    #1 bus1.abort = 1'b1;
    @(posedge clk) #1 bus1.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    chk("abort_strobes", 32'({bus1.rd_en, bus1.mac_en, bus1.mac_last, bus1.done}), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_rd_left", 32'(rd_q.size()), 32'd3);
    chk("abort_wr_left", 32'(wr_q.size()), 32'd2);
    chk("abort_done_left", 32'(lat_q.size()), 32'd1);
    clear_sb();
    push_job(21);
    pulse_start();
    wait_idle("t5");

    // Reset pulse during the drain of element (0,0).
    push_job(21);
    pulse_start();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus1.busy), 32'd0);
    chk("midrst_strobes", 32'({bus1.done, bus1.rd_en, bus1.mac_clr, bus1.mac_en,
                               bus1.mac_last, bus1.wr_en}), 32'd0);
    chk("midrst_addrs", 32'({bus1.rd_addr_b, bus1.wr_addr_r}), 32'd0);
    clear_sb();
    @(negedge clk) rst_n = 1'b1;
    push_job(21);
    pulse_start();
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
